// File: rtl/mult_seq_if.sv
//------------------------------------------------------------------------------
// mult_seq_if : request/result bundle for the mult_seq shift-add multiplier
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mult_seq_if #(
    parameter int WIDTH = 32
);
    logic             START;
    logic             SIGNED;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             BUSY;
    logic             DONE;

    modport master (
        output START, SIGNED, A, B,
        input  HI, LO, BUSY, DONE
    );

    modport slave (
        input  START, SIGNED, A, B,
        output HI, LO, BUSY, DONE
    );
endinterface

`default_nettype wire

// File: rtl/mult_seq.sv
//------------------------------------------------------------------------------
// mult_seq : sequential shift-add multiplier, one multiplier bit per cycle.
//            Signed mode is built only when MULT_SEQ_SIGNED_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mult_seq #(
    parameter int WIDTH = 32
) (
    input  wire logic  CLK,
    input  wire logic  RST,
    mult_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   mcand_q,  mcand_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0]   hi_q,     hi_d;
    logic [WIDTH-1:0]   lo_q,     lo_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_sum;
    logic               w_accept;

    assign w_accept = (state_q == ST_IDLE) && bus.START;

`ifdef MULT_SEQ_SIGNED_EN
    logic w_sgn_mode;
    logic w_neg;
    logic neg_q, neg_d;

    // Operands are reduced to magnitudes so the core loop stays unsigned.
    assign w_sgn_mode = bus.SIGNED;
    assign w_mag_a    = (w_sgn_mode && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign w_mag_b    = (w_sgn_mode && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    assign w_neg      = w_sgn_mode && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
    assign w_prod     = neg_q ? -acc_q : acc_q;

    always_comb begin
        neg_d = neg_q;
        if (w_accept) begin
            neg_d = w_neg;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = bus.SIGNED;
    assign w_mag_a       = bus.A;
    assign w_mag_b       = bus.B;
    assign w_prod        = acc_q;
`endif

    // Upper accumulator half plus the multiplicand, with the carry kept as bit WIDTH.
    assign w_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_W'(WIDTH);
                    mcand_d = w_mag_a;
                    acc_d   = {{WIDTH{1'b0}}, w_mag_b};
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt_q != '0) begin
                    acc_d = {w_sum, acc_q[WIDTH-1:1]};
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    {hi_d, lo_d} = w_prod;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_seq.sv
//------------------------------------------------------------------------------
// tb_mult_seq : directed vector bench for mult_seq (WIDTH=32)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mult_seq;
    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;
`ifdef MULT_SEQ_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;

    mult_seq_if #(.WIDTH(WIDTH)) bus ();

    mult_seq #(.WIDTH(WIDTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi_en;
        logic [31:0] lo_en;
        logic [31:0] hi_dis;
        logic [31:0] lo_dis;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        bus.START  = 1'b1;
        bus.SIGNED = sgn;
        bus.A      = a;
        bus.B      = b;
        @(negedge CLK);
        bus.START  = 1'b0;
        bus.SIGNED = ~sgn;
        bus.A      = $urandom;
        bus.B      = $urandom;
    endtask

    // Counts negedges until DONE (bounded), tracking BUSY and HI/LO stability.
    task automatic wait_done(output int n, output bit busy_ok, output bit hold_ok);
        logic [31:0] h0;
        logic [31:0] l0;
        h0      = bus.HI;
        l0      = bus.LO;
        n       = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (n < 3 * LAT) begin
            @(negedge CLK);
            n++;
            if (bus.DONE) break;
            if (!bus.BUSY) busy_ok = 1'b0;
            if (bus.HI !== h0 || bus.LO !== l0) hold_ok = 1'b0;
        end
    endtask

    task automatic run_and_check(input string nm, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        bit busy_ok;
        bit hold_ok;
        chk({nm, "_busy_start"}, 64'(bus.BUSY), 64'd1);
        wait_done(n, busy_ok, hold_ok);
        chk({nm, "_latency"}, 64'(n), 64'(LAT));
        chk({nm, "_busy_run"}, 64'(busy_ok), 64'd1);
        chk({nm, "_hold_run"}, 64'(hold_ok), 64'd1);
        chk({nm, "_result"}, {bus.HI, bus.LO}, {exp_hi, exp_lo});
        chk({nm, "_busy_done"}, 64'(bus.BUSY), 64'd0);
        @(negedge CLK);
        chk({nm, "_done_pulse"}, 64'(bus.DONE), 64'd0);
    endtask

    initial begin
        int  n;
        bit  busy_ok;
        bit  hold_ok;
        bit  seen;

        vecs[0]  = '{"u3x5",      1'b0, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 32'h00000000, 32'h0000000F};
        vecs[1]  = '{"uones",     1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{"uzero",     1'b0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[3]  = '{"ushift",    1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 32'h00000001, 32'h23456780};
        vecs[4]  = '{"u2p32",     1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 32'h00000001, 32'h00000000};
        vecs[5]  = '{"sneg1x7",   1'b1, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFF9};
        vecs[6]  = '{"sminxmin",  1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 32'h40000000, 32'h00000000};
        vecs[7]  = '{"szeroneg",  1'b1, 32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[8]  = '{"sneg3neg4", 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'h00000000, 32'h0000000C, 32'hFFFFFFF9, 32'h0000000C};
        vecs[9]  = '{"sneg1x2",   1'b1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFE};
        vecs[10] = '{"smaxsq",    1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 32'h3FFFFFFF, 32'h00000001};
        vecs[11] = '{"s5xneg6",   1'b1, 32'h00000005, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFE2, 32'h00000004, 32'hFFFFFFE2};

        bus.START  = 1'b0;
        bus.SIGNED = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        RST        = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;

        chk("reset_hi",   64'(bus.HI),   64'd0);
        chk("reset_lo",   64'(bus.LO),   64'd0);
        chk("reset_busy", 64'(bus.BUSY), 64'd0);
        chk("reset_done", 64'(bus.DONE), 64'd0);

        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].sgn, vecs[i].a, vecs[i].b);
            if (SIGNED_EN) run_and_check(vecs[i].name, vecs[i].hi_en, vecs[i].lo_en);
            else           run_and_check(vecs[i].name, vecs[i].hi_dis, vecs[i].lo_dis);
        end

        // Reset in the middle of an operation must abort it completely.
        launch(1'b0, 32'd6, 32'd7);
        repeat (8) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        chk("abort_hi",   64'(bus.HI),   64'd0);
        chk("abort_lo",   64'(bus.LO),   64'd0);
        chk("abort_busy", 64'(bus.BUSY), 64'd0);
        chk("abort_done", 64'(bus.DONE), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < LAT + 5; c++) begin
            @(negedge CLK);
            if (bus.DONE) seen = 1'b1;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        launch(1'b0, 32'd6, 32'd7);
        run_and_check("after_abort", 32'd0, 32'd42);

        // START held high throughout a run, then accepted in the DONE cycle.
        @(negedge CLK);
        bus.START  = 1'b1;
        bus.SIGNED = 1'b0;
        bus.A      = 32'd11;
        bus.B      = 32'd3;
        @(negedge CLK);
        bus.A      = 32'd9;
        bus.B      = 32'd2;
        bus.SIGNED = 1'b1;
        wait_done(n, busy_ok, hold_ok);
        chk("held_latency", 64'(n), 64'(LAT));
        chk("held_busy",    64'(busy_ok), 64'd1);
        chk("held_result",  {bus.HI, bus.LO}, {32'd0, 32'd33});
        bus.SIGNED = 1'b0;
        @(negedge CLK);
        bus.START = 1'b0;
        wait_done(n, busy_ok, hold_ok);
        chk("b2b_latency", 64'(n), 64'(LAT));
        chk("b2b_busy",    64'(busy_ok), 64'd1);
        chk("b2b_result",  {bus.HI, bus.LO}, {32'd0, 32'd18});
        @(negedge CLK);
        chk("b2b_done_pulse", 64'(bus.DONE), 64'd0);
        chk("b2b_idle_busy",  64'(bus.BUSY), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
